pipe_stage_reg: RTL and testbench
=================================

Name: pipe_stage_reg

Overview:
- Parametrised inter-stage pipeline register for the pipelined CPU. Generalises the fixed EX/MEM latch to configurable data, control and register-number widths and a configurable depth of 1-4 slots.
- Adds a valid bit, stall (hold), flush (bubble injection) and per-slot forwarding taps for the hazard/forwarding unit.
- Adds a saturating counter of flush-injected bubbles for debug.
- Sits between any two pipeline stages; the default configuration replaces the EX/MEM register.

Parameters:
- DATA_W, 32, width of each datapath field (alu result, store operand b).
- RN_W, 5, width of the destination register number.
- CTRL_W, 3, width of the control bundle. Bit 0 = wreg, bit 1 = m2reg, bit 2 = wmem.
- DEPTH, 1, number of register slots in series, legal range 1..4.

Ports:
- clock  in  1  rising-edge clock.
- resetn  in  1  asynchronous active-low reset.
- stall  in  1  hold all slots this cycle.
- flush  in  1  load a bubble into slot 0 instead of the input.
- in_valid  in  1  input instruction is real.
- in_ctrl  in  CTRL_W  control bundle.
- in_rn  in  RN_W  destination register number.
- in_alu  in  DATA_W  ALU result.
- in_b  in  DATA_W  store operand.
- out_valid  out  1  valid bit of slot DEPTH-1.
- out_ctrl  out  CTRL_W  control bundle of slot DEPTH-1.
- out_rn  out  RN_W  register number of slot DEPTH-1.
- out_alu  out  DATA_W  ALU result of slot DEPTH-1.
- out_b  out  DATA_W  store operand of slot DEPTH-1.
- fwd_wreg  out  DEPTH  per slot, valid AND ctrl[0]. Bit k = slot k.
- fwd_rn  out  DEPTH*RN_W  per-slot rn. Slot k occupies bits [k*RN_W +: RN_W].
- bubble_cnt  out  16  count of flush-injected bubbles.

Behaviour:
- Clock and reset: one clock, named clock. Reset resetn is asynchronous and active-low.
- Reset: every slot is cleared (valid=0, ctrl=0, rn=0, alu=0, b=0) and bubble_cnt=0. Consequently all outputs are 0 and fwd_wreg=0.
- Reset mid-operation discards all slot contents immediately, without waiting for a clock edge.
- Slot k state: valid, ctrl, rn, alu, b. All outputs are driven directly from flops; there is no combinational path from inputs to outputs.
- Bubble: valid=0, ctrl=0, rn=0, alu=0, b=0.
- Gating on load: whenever slot 0 loads with in_valid=0, the slot gets a bubble regardless of the other inputs. No write can leak from an invalid input.
- Per rising edge, with priority top-down:
  - stall=1, flush=1: slots 1..DEPTH-1 hold; slot 0 loads a bubble; bubble_cnt increments.
  - stall=1, flush=0: all slots hold; bubble_cnt holds.
  - stall=0, flush=1: slots shift (slot k takes slot k-1); slot 0 loads a bubble; bubble_cnt increments.
  - stall=0, flush=0: slots shift; slot 0 loads the gated input.
- Latency: DEPTH cycles from input to out_* when no stall occurs. Each stall cycle adds one cycle.
- bubble_cnt saturates at 16'hFFFF and never wraps.
- fwd_* reflect the registered slot state in the same cycle, for comparison against source register numbers by the forwarding unit.
- DEPTH=1: slot 0 is the output slot; the shift path is absent.
- Legality: DEPTH outside 1..4 is a configuration error, flagged by an elaboration-time check.

Decomposition:
- Shared package pipe_pkg:
  - Control bit indices CTRL_WREG=0, CTRL_M2REG=1, CTRL_WMEM=2.
  - Default widths DATA_W=32, RN_W=5, CTRL_W=3.
  - Bubble-count width 16 and saturation value.
- Sub-module pipe_slot: one slot's flops. Inputs are hold, load_bubble, and the slot's input fields. pipe_stage_reg instantiates DEPTH copies in a generate chain and owns bubble_cnt.

Test Plan:
- Reset: DEPTH=1; assert resetn=0 mid-stream while out_valid=1 -> outputs go to 0 immediately, without a clock edge; after release, the first input with in_valid=1, ctrl=3'b001, rn=5'd7, alu=32'h1234 appears on out_* one edge later.
- Latency: DEPTH=3; stream 4 valid entries, alu=1..4, no stall -> out_alu shows 1,2,3,4 on edges 3..6. fwd_rn slot-major matches each entry's progress.
- Stall: DEPTH=2; hold stall=1 for 2 edges mid-stream -> all slots and out_* unchanged for those edges, bubble_cnt unchanged; the stream resumes with no loss or duplication.
- Flush priority: DEPTH=2; assert stall=1 and flush=1 together with in_valid=1, ctrl=3'b111 -> slot 1 holds, slot 0 becomes a bubble, fwd_wreg[0]=0, bubble_cnt=1.
- Gating: in_valid=0 with ctrl=3'b111, rn=5'd31 -> loaded slot shows ctrl=0, rn=0, fwd_wreg bit=0; no memory-write pulse ever reaches out_ctrl.
- Saturation: force 65537 flush cycles -> bubble_cnt stops at 16'hFFFF and does not wrap to 0.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared constants for the configurable inter-stage pipeline register:
// control-bit positions, default field widths and the bubble counter limits.
package pipe_pkg;

    localparam int unsigned CTRL_WREG  = 0;
    localparam int unsigned CTRL_M2REG = 1;
    localparam int unsigned CTRL_WMEM  = 2;

    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned DEF_RN_W   = 5;
    localparam int unsigned DEF_CTRL_W = 3;

    localparam int unsigned             BUBBLE_CNT_W   = 16;
    localparam logic [BUBBLE_CNT_W-1:0] BUBBLE_CNT_MAX = 16'hFFFF;

    // Increment that sticks at the maximum instead of wrapping.
    function automatic logic [BUBBLE_CNT_W-1:0] sat_inc(input logic [BUBBLE_CNT_W-1:0] cnt);
        return (cnt == BUBBLE_CNT_MAX) ? cnt : cnt + 1'b1;
    endfunction

endpackage

// File: rtl/pipe_slot.sv
// One pipeline slot: valid, ctrl, rn, alu and b flops with hold and bubble load.
// An invalid incoming entry is always stored as a full bubble.
module pipe_slot
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned RN_W   = DEF_RN_W,
    parameter int unsigned CTRL_W = DEF_CTRL_W
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              hold_i,
    input  logic              load_bubble_i,
    input  logic              valid_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    input  logic [RN_W-1:0]   rn_i,
    input  logic [DATA_W-1:0] alu_i,
    input  logic [DATA_W-1:0] b_i,
    output logic              valid_o,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic [RN_W-1:0]   rn_o,
    output logic [DATA_W-1:0] alu_o,
    output logic [DATA_W-1:0] b_o
);

    logic              valid_q, valid_d;
    logic [CTRL_W-1:0] ctrl_q,  ctrl_d;
    logic [RN_W-1:0]   rn_q,    rn_d;
    logic [DATA_W-1:0] alu_q,   alu_d;
    logic [DATA_W-1:0] b_q,     b_d;

    always_comb begin
        valid_d = valid_q;
        ctrl_d  = ctrl_q;
        rn_d    = rn_q;
        alu_d   = alu_q;
        b_d     = b_q;
        if (!hold_i) begin
            if (load_bubble_i || !valid_i) begin
                valid_d = 1'b0;
                ctrl_d  = '0;
                rn_d    = '0;
                alu_d   = '0;
                b_d     = '0;
            end else begin
                valid_d = 1'b1;
                ctrl_d  = ctrl_i;
                rn_d    = rn_i;
                alu_d   = alu_i;
                b_d     = b_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            rn_q    <= '0;
            alu_q   <= '0;
            b_q     <= '0;
        end else begin
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
            rn_q    <= rn_d;
            alu_q   <= alu_d;
            b_q     <= b_d;
        end
    end

    assign valid_o = valid_q;
    assign ctrl_o  = ctrl_q;
    assign rn_o    = rn_q;
    assign alu_o   = alu_q;
    assign b_o     = b_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Parametrised inter-stage pipeline register: DEPTH slots in series with stall, flush,
// per-slot forwarding taps and a saturating count of flush-injected bubbles.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned RN_W   = DEF_RN_W,
    parameter int unsigned CTRL_W = DEF_CTRL_W,
    parameter int unsigned DEPTH  = 1
) (
    input  logic                    clock,
    input  logic                    resetn,
    input  logic                    stall,
    input  logic                    flush,
    input  logic                    in_valid,
    input  logic [CTRL_W-1:0]       in_ctrl,
    input  logic [RN_W-1:0]         in_rn,
    input  logic [DATA_W-1:0]       in_alu,
    input  logic [DATA_W-1:0]       in_b,
    output logic                    out_valid,
    output logic [CTRL_W-1:0]       out_ctrl,
    output logic [RN_W-1:0]         out_rn,
    output logic [DATA_W-1:0]       out_alu,
    output logic [DATA_W-1:0]       out_b,
    output logic [DEPTH-1:0]        fwd_wreg,
    output logic [DEPTH*RN_W-1:0]   fwd_rn,
    output logic [BUBBLE_CNT_W-1:0] bubble_cnt
);

    if (DEPTH < 1 || DEPTH > 4) begin : g_depth_check
        $error("pipe_stage_reg: DEPTH must be in 1..4");
    end

    logic              valid_s [DEPTH];
    logic [CTRL_W-1:0] ctrl_s  [DEPTH];
    logic [RN_W-1:0]   rn_s    [DEPTH];
    logic [DATA_W-1:0] alu_s   [DEPTH];
    logic [DATA_W-1:0] b_s     [DEPTH];

    for (genvar k = 0; k < DEPTH; k++) begin : g_slot
        logic              hold;
        logic              load_bubble;
        logic              v_in;
        logic [CTRL_W-1:0] c_in;
        logic [RN_W-1:0]   rn_in;
        logic [DATA_W-1:0] alu_in;
        logic [DATA_W-1:0] b_in;

        if (k == 0) begin : g_head
            // A flush wins over a stall for slot 0 only; later slots still hold.
            assign hold        = stall & ~flush;
            assign load_bubble = flush;
            assign v_in        = in_valid;
            assign c_in        = in_ctrl;
            assign rn_in       = in_rn;
            assign alu_in      = in_alu;
            assign b_in        = in_b;
        end else begin : g_tail
            assign hold        = stall;
            assign load_bubble = 1'b0;
            assign v_in        = valid_s[k-1];
            assign c_in        = ctrl_s[k-1];
            assign rn_in       = rn_s[k-1];
            assign alu_in      = alu_s[k-1];
            assign b_in        = b_s[k-1];
        end

        pipe_slot #(
            .DATA_W(DATA_W),
            .RN_W  (RN_W),
            .CTRL_W(CTRL_W)
        ) u_slot (
            .clk_i        (clock),
            .rst_ni       (resetn),
            .hold_i       (hold),
            .load_bubble_i(load_bubble),
            .valid_i      (v_in),
            .ctrl_i       (c_in),
            .rn_i         (rn_in),
            .alu_i        (alu_in),
            .b_i          (b_in),
            .valid_o      (valid_s[k]),
            .ctrl_o       (ctrl_s[k]),
            .rn_o         (rn_s[k]),
            .alu_o        (alu_s[k]),
            .b_o          (b_s[k])
        );

        assign fwd_wreg[k]              = valid_s[k] & ctrl_s[k][CTRL_WREG];
        assign fwd_rn[k*RN_W +: RN_W]   = rn_s[k];
    end

    assign out_valid = valid_s[DEPTH-1];
    assign out_ctrl  = ctrl_s[DEPTH-1];
    assign out_rn    = rn_s[DEPTH-1];
    assign out_alu   = alu_s[DEPTH-1];
    assign out_b     = b_s[DEPTH-1];

    logic [BUBBLE_CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

    always_comb begin
        bubble_cnt_d = bubble_cnt_q;
        if (flush) begin
            bubble_cnt_d = sat_inc(bubble_cnt_q);
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            bubble_cnt_q <= '0;
        end else begin
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign bubble_cnt = bubble_cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: DEPTH 1..4 instances share one stimulus stream and are
// compared against a queue-based model, a vector table and directed corner sequences.
module tb_pipe_stage_reg;

    logic        clock = 1'b0;
    logic        resetn;
    logic        stall, flush, in_valid;
    logic [2:0]  in_ctrl;
    logic [4:0]  in_rn;
    logic [31:0] in_alu, in_b;

    logic        o_valid    [4];
    logic [2:0]  o_ctrl     [4];
    logic [4:0]  o_rn       [4];
    logic [31:0] o_alu      [4];
    logic [31:0] o_b        [4];
    logic [3:0]  o_fwd_wreg [4];
    logic [19:0] o_fwd_rn   [4];
    logic [15:0] o_cnt      [4];

    always #5 clock = ~clock;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int unsigned D = g + 1;
        logic [D-1:0]   fw;
        logic [D*5-1:0] fr;
        pipe_stage_reg #(.DATA_W(32), .RN_W(5), .CTRL_W(3), .DEPTH(D)) u_dut (
            .clock     (clock),
            .resetn    (resetn),
            .stall     (stall),
            .flush     (flush),
            .in_valid  (in_valid),
            .in_ctrl   (in_ctrl),
            .in_rn     (in_rn),
            .in_alu    (in_alu),
            .in_b      (in_b),
            .out_valid (o_valid[g]),
            .out_ctrl  (o_ctrl[g]),
            .out_rn    (o_rn[g]),
            .out_alu   (o_alu[g]),
            .out_b     (o_b[g]),
            .fwd_wreg  (fw),
            .fwd_rn    (fr),
            .bubble_cnt(o_cnt[g])
        );
        assign o_fwd_wreg[g] = 4'(fw);
        assign o_fwd_rn[g]   = 20'(fr);
    end

    // Reference model: each pipeline is a queue of entries, index 0 = newest slot.
    typedef struct packed {
        logic        v;
        logic [2:0]  c;
        logic [4:0]  rn;
        logic [31:0] alu;
        logic [31:0] b;
    } ent_t;

    ent_t mq [4][$];
    int   mflush;
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        mflush = 0;
        for (int d = 0; d < 4; d++) begin
            mq[d] = {};
            for (int k = 0; k <= d; k++) mq[d].push_back('0);
        end
    endtask

    task automatic model_step(input logic st, input logic fl, input ent_t e_in);
        ent_t e;
        e = e_in.v ? e_in : ent_t'('0);
        for (int d = 0; d < 4; d++) begin
            if (st) begin
                if (fl) mq[d][0] = '0;
            end else begin
                mq[d].push_front(fl ? ent_t'('0) : e);
                void'(mq[d].pop_back());
            end
        end
        if (fl) mflush++;
    endtask

    task automatic check_all(input string name);
        for (int d = 0; d < 4; d++) begin
            ent_t        last;
            logic [3:0]  ew;
            logic [19:0] er;
            ew   = '0;
            er   = '0;
            last = mq[d][d];
            for (int k = 0; k <= d; k++) begin
                ew[k]          = mq[d][k].v & mq[d][k].c[0];
                er[k*5 +: 5]   = mq[d][k].rn;
            end
            chk($sformatf("%s d%0d valid", name, d + 1), 64'(o_valid[d]), 64'(last.v));
            chk($sformatf("%s d%0d ctrl", name, d + 1), 64'(o_ctrl[d]), 64'(last.c));
            chk($sformatf("%s d%0d rn", name, d + 1), 64'(o_rn[d]), 64'(last.rn));
            chk($sformatf("%s d%0d alu", name, d + 1), 64'(o_alu[d]), 64'(last.alu));
            chk($sformatf("%s d%0d b", name, d + 1), 64'(o_b[d]), 64'(last.b));
            chk($sformatf("%s d%0d fwd_wreg", name, d + 1), 64'(o_fwd_wreg[d]), 64'(ew));
            chk($sformatf("%s d%0d fwd_rn", name, d + 1), 64'(o_fwd_rn[d]), 64'(er));
            chk($sformatf("%s d%0d bubble_cnt", name, d + 1), 64'(o_cnt[d]),
                64'((mflush > 65535) ? 65535 : mflush));
        end
    endtask

    // Drive one cycle's inputs, take the edge, then sample 1 time unit later.
    task automatic step(input logic st, input logic fl, input logic v, input logic [2:0] c,
                        input logic [4:0] rn, input logic [31:0] alu, input logic [31:0] b);
        ent_t e;
        stall    = st;
        flush    = fl;
        in_valid = v;
        in_ctrl  = c;
        in_rn    = rn;
        in_alu   = alu;
        in_b     = b;
        e        = '{v: v, c: c, rn: rn, alu: alu, b: b};
        @(posedge clock);
        model_step(st, fl, e);
        #1;
    endtask

    // Asynchronous reset applied between edges; outputs must clear before any edge.
    task automatic do_reset(input string name);
        #2 resetn = 1'b0;
        #1;
        model_reset();
        check_all(name);
        #3 resetn = 1'b1;
    endtask

    typedef struct {
        logic        st, fl, v;
        logic [2:0]  c;
        logic [4:0]  rn;
        logic [31:0] alu, b;
        logic        ev;
        logic [2:0]  ec;
        logic [4:0]  ern;
        logic [31:0] ealu, eb;
        logic [15:0] ecnt;
    } vec_t;

    vec_t tbl [10];

    initial begin
        // Expected values are for the DEPTH=1 instance, starting from reset.
        tbl[0] = '{0, 0, 1, 3'b001, 5'd7,  32'h1234, 32'h5678, 1, 3'b001, 5'd7,  32'h1234, 32'h5678, 0};
        tbl[1] = '{0, 0, 0, 3'b111, 5'd31, 32'hffff, 32'hffff, 0, 3'b000, 5'd0,  32'h0,    32'h0,    0};
        tbl[2] = '{0, 0, 1, 3'b111, 5'd3,  32'haa,   32'hbb,   1, 3'b111, 5'd3,  32'haa,   32'hbb,   0};
        tbl[3] = '{1, 0, 1, 3'b010, 5'd4,  32'hcc,   32'hdd,   1, 3'b111, 5'd3,  32'haa,   32'hbb,   0};
        tbl[4] = '{1, 1, 1, 3'b111, 5'd5,  32'hee,   32'hff,   0, 3'b000, 5'd0,  32'h0,    32'h0,    1};
        tbl[5] = '{0, 0, 1, 3'b011, 5'd9,  32'h11,   32'h22,   1, 3'b011, 5'd9,  32'h11,   32'h22,   1};
        tbl[6] = '{0, 1, 1, 3'b001, 5'd10, 32'h33,   32'h44,   0, 3'b000, 5'd0,  32'h0,    32'h0,    2};
        tbl[7] = '{0, 0, 1, 3'b101, 5'd12, 32'h55,   32'h66,   1, 3'b101, 5'd12, 32'h55,   32'h66,   2};
        tbl[8] = '{1, 0, 0, 3'b000, 5'd0,  32'h0,    32'h0,    1, 3'b101, 5'd12, 32'h55,   32'h66,   2};
        tbl[9] = '{0, 0, 0, 3'b001, 5'd1,  32'h1,    32'h1,    0, 3'b000, 5'd0,  32'h0,    32'h0,    2};

        resetn   = 1'b0;
        stall    = 1'b0;
        flush    = 1'b0;
        in_valid = 1'b0;
        in_ctrl  = '0;
        in_rn    = '0;
        in_alu   = '0;
        in_b     = '0;
        model_reset();
        #3;
        check_all("reset");
        #4 resetn = 1'b1;

        for (int i = 0; i < 10; i++) begin
            step(tbl[i].st, tbl[i].fl, tbl[i].v, tbl[i].c, tbl[i].rn, tbl[i].alu, tbl[i].b);
            chk($sformatf("tbl%0d valid", i), 64'(o_valid[0]), 64'(tbl[i].ev));
            chk($sformatf("tbl%0d ctrl", i), 64'(o_ctrl[0]), 64'(tbl[i].ec));
            chk($sformatf("tbl%0d rn", i), 64'(o_rn[0]), 64'(tbl[i].ern));
            chk($sformatf("tbl%0d alu", i), 64'(o_alu[0]), 64'(tbl[i].ealu));
            chk($sformatf("tbl%0d b", i), 64'(o_b[0]), 64'(tbl[i].eb));
            chk($sformatf("tbl%0d cnt", i), 64'(o_cnt[0]), 64'(tbl[i].ecnt));
            check_all($sformatf("tbl%0d", i));
        end

        // Mid-stream reset while the DEPTH=1 output holds a valid entry.
        step(0, 0, 1, 3'b001, 5'd2, 32'h77, 32'h88);
        chk("pre_rst d1 valid", 64'(o_valid[0]), 64'd1);
        do_reset("mid_rst");

        // Latency stream: alu 1..4 reaches DEPTH=3 output on edges 3..6.
        for (int i = 1; i <= 8; i++) begin
            step(0, 0, i <= 4, 3'b001, 5'(i), 32'(i), ~32'(i));
            chk($sformatf("lat e%0d d3 alu", i), 64'(o_alu[2]),
                64'((i >= 3 && i <= 6) ? i - 2 : 0));
            if (i == 1) chk("post_rst d1 alu", 64'(o_alu[0]), 64'd1);
            check_all($sformatf("lat e%0d", i));
        end

        // Flush priority over stall on DEPTH=2.
        do_reset("rst2");
        step(0, 0, 1, 3'b001, 5'd4, 32'h40, 32'h0);
        step(0, 0, 1, 3'b001, 5'd5, 32'h50, 32'h0);
        step(1, 1, 1, 3'b111, 5'd6, 32'h60, 32'h0);
        chk("flushpri d2 fwd_wreg", 64'(o_fwd_wreg[1]), 64'b10);
        chk("flushpri d2 fwd_rn", 64'(o_fwd_rn[1]), 64'(5'd4) << 5);
        chk("flushpri d2 cnt", 64'(o_cnt[1]), 64'd1);
        chk("flushpri d2 out_alu", 64'(o_alu[1]), 64'h40);
        check_all("flushpri");

        // Stall for two edges mid-stream, then resume.
        step(0, 0, 1, 3'b101, 5'd8, 32'h80, 32'h81);
        step(1, 0, 1, 3'b111, 5'd9, 32'h90, 32'h91);
        check_all("stall1");
        step(1, 0, 0, 3'b111, 5'd31, 32'h99, 32'h99);
        check_all("stall2");
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 1, 3'b001, 5'(10 + i), 32'(200 + i), 32'(300 + i));
            check_all($sformatf("resume%0d", i));
        end

        // Randomised traffic.
        for (int i = 0; i < 1500; i++) begin
            step(($urandom % 4) == 0, ($urandom % 8) == 0, ($urandom % 10) < 7,
                 3'($urandom), 5'($urandom), $urandom, $urandom);
            check_all($sformatf("rnd%0d", i));
        end

        // Counter saturation.
        do_reset("rst_sat");
        for (int i = 0; i < 65534; i++) begin
            step($urandom % 2, 1, 1, 3'b111, 5'd1, 32'h1, 32'h1);
        end
        chk("sat pre d1 cnt", 64'(o_cnt[0]), 64'hfffe);
        check_all("sat_pre");
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 1, 3'b111, 5'd1, 32'h1, 32'h1);
            chk($sformatf("sat%0d d1 cnt", i), 64'(o_cnt[0]), 64'hffff);
            check_all($sformatf("sat%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
